// File: rtl/vga_sync_core.sv
// vga_sync_core
// VGA timing generator (640x480@60 Hz by default). Free-running horizontal and
// vertical pixel counters are decoded into sync pulses, a display-enable and the
// pixel coordinates for a downstream pattern/framebuffer block.
//
// Ports
//   vga_clk_in  in   1   pixel clock, all logic on the rising edge
//   reset_in    in   1   asynchronous, active-high reset
//   blank_n     out  1   1 = inside the visible area, 0 = blanking
//   h_sync_out  out  1   horizontal sync, active level = SYNC_POL
//   v_sync_out  out  1   vertical sync, active level = SYNC_POL
//   pixel_x     out  10  horizontal count of the decoded pixel
//   pixel_y     out  10  vertical count of the decoded pixel
//
// All outputs are flops holding the decode of the pre-edge counter values, so
// they lag the counters by one clock and pixel_x/pixel_y always describe the
// same pixel that blank_n and the syncs describe.
module vga_sync_core #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       vga_clk_in,
    input  logic       reset_in,
    output logic       blank_n,
    output logic       h_sync_out,
    output logic       v_sync_out,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y
);

    localparam int H_T = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_T = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Segment boundaries as 10-bit constants; the counters are 10 bits wide,
    // which covers totals up to 1024.
    localparam logic [9:0] H_ACT_END   = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_LAST = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST      = 10'(H_T - 1);
    localparam logic [9:0] V_ACT_END   = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_LAST = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST      = 10'(V_T - 1);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;
    logic       v_wrap;
    logic       vis_d;
    logic       h_sync_act_d;
    logic       v_sync_act_d;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge vga_clk_in or posedge reset_in) begin
        if (reset_in) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            if (h_wrap) begin
                h_cnt <= '0;
                // Vertical only advances on the edge that ends a line.
                v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        vis_d        = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        h_sync_act_d = (h_cnt >= H_SYNC_BEG) && (h_cnt <= H_SYNC_LAST);
        v_sync_act_d = (v_cnt >= V_SYNC_BEG) && (v_cnt <= V_SYNC_LAST);
    end

    // Syncs come straight from flops so they cannot glitch.
    always_ff @(posedge vga_clk_in or posedge reset_in) begin
        if (reset_in) begin
            blank_n    <= 1'b0;
            h_sync_out <= ~SYNC_POL;
            v_sync_out <= ~SYNC_POL;
            pixel_x    <= '0;
            pixel_y    <= '0;
        end else begin
            blank_n    <= vis_d;
            h_sync_out <= h_sync_act_d ? SYNC_POL : ~SYNC_POL;
            v_sync_out <= v_sync_act_d ? SYNC_POL : ~SYNC_POL;
            pixel_x    <= h_cnt;
            pixel_y    <= v_cnt;
        end
    end

endmodule

// File: tb/tb_vga_sync_core.sv
// Bench for vga_sync_core. One instance runs the full 640x480 timing for the
// horizontal checks; a second instance with a shortened vertical frame
// (4 active, 2 fp, 2 sync, 3 bp lines -> 11 lines) exercises the vertical
// decode and frame wrap within a short run. Edge n after reset release
// decodes count n-1.
module tb_vga_sync_core;

    logic       clk;
    logic       rst;
    logic       blank_n,   h_sync,   v_sync;
    logic [9:0] px,        py;
    logic       v_blank_n, v_h_sync, v_v_sync;
    logic [9:0] v_px,      v_py;

    int checks   = 0;
    int failures = 0;
    int cur_edge = 0;

    vga_sync_core dut (
        .vga_clk_in (clk),
        .reset_in   (rst),
        .blank_n    (blank_n),
        .h_sync_out (h_sync),
        .v_sync_out (v_sync),
        .pixel_x    (px),
        .pixel_y    (py)
    );

    vga_sync_core #(
        .V_ACTIVE (4),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3)
    ) dut_v (
        .vga_clk_in (clk),
        .reset_in   (rst),
        .blank_n    (v_blank_n),
        .h_sync_out (v_h_sync),
        .v_sync_out (v_v_sync),
        .pixel_x    (v_px),
        .pixel_y    (v_py)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to edge n after release and sample 1 ns later.
    task automatic go_to(input int n);
        while (cur_edge < n) begin
            @(posedge clk);
            cur_edge++;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        #1;
        check_val("rst_blank", int'(blank_n), 0);
        check_val("rst_hsync", int'(h_sync), 1);
        check_val("rst_vsync", int'(v_sync), 1);
        check_val("rst_px", int'(px), 0);
        check_val("rst_py", int'(py), 0);
        #1 rst = 1'b0;

        // Horizontal timing, full-size instance.
        go_to(1);
        check_val("e1_blank", int'(blank_n), 1);
        check_val("e1_px", int'(px), 0);
        check_val("e1_hsync", int'(h_sync), 1);
        go_to(640);
        check_val("e640_blank", int'(blank_n), 1);
        check_val("e640_px", int'(px), 639);
        go_to(641);
        check_val("e641_blank", int'(blank_n), 0);
        check_val("e641_px", int'(px), 640);
        go_to(656);
        check_val("e656_hsync", int'(h_sync), 1);
        go_to(657);
        check_val("e657_hsync", int'(h_sync), 0);
        check_val("e657_v_hsync", int'(v_h_sync), 0);
        go_to(752);
        check_val("e752_hsync", int'(h_sync), 0);
        go_to(753);
        check_val("e753_hsync", int'(h_sync), 1);
        go_to(800);
        check_val("e800_px", int'(px), 799);
        check_val("e800_py", int'(py), 0);
        go_to(801);
        check_val("e801_blank", int'(blank_n), 1);
        check_val("e801_px", int'(px), 0);
        check_val("e801_py", int'(py), 1);
        check_val("e801_vsync", int'(v_sync), 1);
        go_to(1456);
        check_val("e1456_hsync", int'(h_sync), 1);
        go_to(1457);
        check_val("e1457_hsync", int'(h_sync), 0);

        // Mid-line reset while h_sync is low (h_cnt=700): outputs clear with no edge.
        go_to(1501);
        check_val("e1501_hsync", int'(h_sync), 0);
        check_val("e1501_px", int'(px), 700);
        rst = 1'b1;
        #2;
        check_val("arst_hsync", int'(h_sync), 1);
        check_val("arst_blank", int'(blank_n), 0);
        check_val("arst_px", int'(px), 0);
        check_val("arst_py", int'(py), 0);
        #2 rst = 1'b0;
        cur_edge = 0;
        go_to(1);
        check_val("re1_blank", int'(blank_n), 1);
        check_val("re1_px", int'(px), 0);
        check_val("re1_py", int'(py), 0);
        go_to(641);
        check_val("re641_blank", int'(blank_n), 0);

        // Vertical timing on the short-frame instance (v_sync on lines 6..7).
        go_to(2401);
        check_val("v_e2401_blank", int'(v_blank_n), 1);
        check_val("v_e2401_py", int'(v_py), 3);
        go_to(3201);
        check_val("v_e3201_blank", int'(v_blank_n), 0);
        check_val("v_e3201_py", int'(v_py), 4);
        go_to(4800);
        check_val("v_e4800_vsync", int'(v_v_sync), 1);
        go_to(4801);
        check_val("v_e4801_vsync", int'(v_v_sync), 0);
        check_val("e4801_py", int'(py), 6);
        check_val("e4801_vsync", int'(v_sync), 1);
        go_to(6400);
        check_val("v_e6400_vsync", int'(v_v_sync), 0);
        go_to(6401);
        check_val("v_e6401_vsync", int'(v_v_sync), 1);
        go_to(8001);
        check_val("v_e8001_blank", int'(v_blank_n), 0);
        check_val("v_e8001_py", int'(v_py), 10);
        go_to(8800);
        check_val("v_e8800_px", int'(v_px), 799);
        check_val("v_e8800_py", int'(v_py), 10);
        go_to(8801);
        check_val("v_wrap_px", int'(v_px), 0);
        check_val("v_wrap_py", int'(v_py), 0);
        check_val("v_wrap_blank", int'(v_blank_n), 1);
        check_val("e8801_py", int'(py), 11);
        go_to(13600);
        check_val("v_e13600_vsync", int'(v_v_sync), 1);
        go_to(13601);
        check_val("v_e13601_vsync", int'(v_v_sync), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
